// File: rtl/m_mem_access_unit.sv
// M-stage data-memory access unit: one load/store at a time over valid/ready,
// lane steering and extension, req/ack bus with misalignment and timeout exceptions.
module m_mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_exc,
  output logic                  busy
);

  localparam int NB     = DATA_W / 8;
  localparam int OFFW   = $clog2(NB);
  localparam int CNTW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]      MAX_SZ  = 3'(OFFW);
  localparam logic [CNTW-1:0] CNT_END = CNTW'(TIMEOUT - 1);

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_TMO   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Low (8 << sz) bits set; full width when the access covers the whole bus.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] sz);
    return ~({DATA_W{1'b1}} << (7'd8 << sz));
  endfunction

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [OFFW-1:0]   off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;

  // Request decode, evaluated on the incoming fields at the accept edge
  logic [3:0]        in_bytes;
  logic [OFFW-1:0]   in_off;
  logic              in_legal;
  logic [NB-1:0]     in_be;
  logic [DATA_W-1:0] in_wdata;

  assign in_bytes = 4'd1 << req_size;
  assign in_off   = req_addr[OFFW-1:0];
  assign in_legal = ({1'b0, req_size} <= MAX_SZ) &&
                    ((4'(in_off) & (in_bytes - 4'd1)) == 4'd0);
  assign in_be    = (~({NB{1'b1}} << in_bytes)) << in_off;
  assign in_wdata = (req_wdata & lane_mask(req_size)) << {in_off, 3'b000};

  // Load extraction from the captured offset/size
  logic [DATA_W-1:0] ld_sh, ld_mask, ld_ext;
  logic              ld_sgn;

  assign ld_sh   = bus_rdata >> {off_q, 3'b000};
  assign ld_mask = lane_mask(size_q);

  always_comb begin
    case (size_q)
      2'd0:    ld_sgn = ld_sh[7];
      2'd1:    ld_sgn = ld_sh[15];
      2'd2:    ld_sgn = ld_sh[31];
      default: ld_sgn = ld_sh[DATA_W-1];
    endcase
  end

  // For a full-width load ~ld_mask is zero, so the data passes unchanged.
  assign ld_ext = (ld_sh & ld_mask) | ((!uns_q && ld_sgn) ? ~ld_mask : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          rdata_d = '0;
          if (in_legal) begin
            state_d = S_BUS;
            exc_d   = EXC_NONE;
          end else begin
            state_d = S_RESP;
            exc_d   = EXC_ALIGN;
          end
        end
      end
      S_BUS: begin
        if (bus_ack) begin
          state_d = S_RESP;
          exc_d   = EXC_NONE;
          rdata_d = we_q ? '0 : ld_ext;
        end else if (cnt_q == CNT_END) begin
          state_d = S_RESP;
          exc_d   = EXC_TMO;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  // Captured request; be/wdata are pre-steered so the bus sees stable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      off_q   <= in_off;
      addr_q  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
      be_q    <= (req_we && in_legal) ? in_be : '0;
      wdata_q <= (req_we && in_legal) ? in_wdata : '0;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign bus_req   = (state_q == S_BUS);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? addr_q  : '0;
  assign bus_be    = bus_req ? be_q    : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_exc   = rsp_valid ? exc_q   : EXC_NONE;

endmodule

// File: tb/tb_m_mem_access_unit.sv
// Directed bench for m_mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance, with expected responses queued at issue and popped on rsp_valid.
module tb_m_mem_access_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        v32 = 0, we32 = 0, un32 = 0, back32 = 0;
  logic [1:0]  sz32 = 0;
  logic [31:0] addr32 = 0, wd32 = 0, brd32 = 0;
  logic        rdy32, breq32, bwe32, rv32, busy32;
  logic [31:0] baddr32, bwd32, rrd32;
  logic [3:0]  bbe32;
  logic [1:0]  rexc32;

  // 64-bit instance
  logic        v64 = 0, we64 = 0, un64 = 0, back64 = 0;
  logic [1:0]  sz64 = 0;
  logic [31:0] addr64 = 0;
  logic [63:0] wd64 = 0, brd64 = 0;
  logic        rdy64, breq64, bwe64, rv64, busy64;
  logic [31:0] baddr64;
  logic [63:0] bwd64, rrd64;
  logic [7:0]  bbe64;
  logic [1:0]  rexc64;

  m_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) d32 (
    .clk(clk), .reset_n(reset_n), .req_valid(v32), .req_ready(rdy32),
    .req_we(we32), .req_size(sz32), .req_unsigned(un32), .req_addr(addr32),
    .req_wdata(wd32), .bus_req(breq32), .bus_we(bwe32), .bus_addr(baddr32),
    .bus_be(bbe32), .bus_wdata(bwd32), .bus_ack(back32), .bus_rdata(brd32),
    .rsp_valid(rv32), .rsp_rdata(rrd32), .rsp_exc(rexc32), .busy(busy32));

  m_mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) d64 (
    .clk(clk), .reset_n(reset_n), .req_valid(v64), .req_ready(rdy64),
    .req_we(we64), .req_size(sz64), .req_unsigned(un64), .req_addr(addr64),
    .req_wdata(wd64), .bus_req(breq64), .bus_we(bwe64), .bus_addr(baddr64),
    .bus_be(bbe64), .bus_wdata(bwd64), .bus_ack(back64), .bus_rdata(brd64),
    .rsp_valid(rv64), .rsp_rdata(rrd64), .rsp_exc(rexc64), .busy(busy64));

  typedef struct {
    logic [63:0] rd;
    logic [1:0]  exc;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_check(input string tag, input logic [63:0] rd, input logic [1:0] exc);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rd, e.rd);
      chk({tag, "_exc"}, 64'(exc), 64'(e.exc));
    end
  endtask

  // Issue one request, ack it in cycle ack_cyc (0 = never), and check the bus
  // phase plus the response. Cycle 1 is the cycle after the accept edge.
  task automatic run(input string tag, input bit w64, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                     input int ack_cyc, input logic [63:0] rdata,
                     input logic [63:0] exp_rd, input logic [1:0] exp_exc,
                     input int exp_rsp, input int exp_nreq,
                     input logic [7:0] exp_be, input logic [63:0] exp_wd);
    int nreq;
    bit got;
    logic o_req, o_rv, o_we;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_rd;
    logic [1:0]  o_exc;
    exp_t e;
    @(negedge clk);
    if (w64) begin
      v64 = 1; we64 = we; sz64 = sz; un64 = uns; addr64 = addr; wd64 = wdata;
    end else begin
      v32 = 1; we32 = we; sz32 = sz; un32 = uns; addr32 = addr; wd32 = wdata[31:0];
    end
    e.rd = exp_rd; e.exc = exp_exc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    v32 = 0; v64 = 0;
    nreq = 0; got = 0;
    for (int k = 1; k <= 24 && !got; k++) begin
      @(negedge clk);
      o_req  = w64 ? breq64 : breq32;
      o_rv   = w64 ? rv64   : rv32;
      o_we   = w64 ? bwe64  : bwe32;
      o_addr = w64 ? baddr64 : baddr32;
      o_be   = w64 ? bbe64  : {4'h0, bbe32};
      o_wd   = w64 ? bwd64  : {32'h0, bwd32};
      o_rd   = w64 ? rrd64  : {32'h0, rrd32};
      o_exc  = w64 ? rexc64 : rexc32;
      if (o_req) begin
        nreq++;
        if (nreq == 1) begin
          chk({tag, "_bus_addr"}, 64'(o_addr), 64'(addr & ~(w64 ? 32'h7 : 32'h3)));
          chk({tag, "_bus_we"}, 64'(o_we), 64'(we));
          if (we) begin
            chk({tag, "_bus_be"}, 64'(o_be), 64'(exp_be));
            chk({tag, "_bus_wdata"}, o_wd, exp_wd);
          end
        end
      end
      if (o_rv) begin
        got = 1;
        chk({tag, "_rsp_cycle"}, 64'(k), 64'(exp_rsp));
        sb_check(tag, o_rd, o_exc);
      end
      if (w64) begin
        back64 = (k == ack_cyc); brd64 = rdata;
      end else begin
        back32 = (k == ack_cyc); brd32 = rdata[31:0];
      end
    end
    back32 = 0; back64 = 0;
    if (!got) chk({tag, "_rsp_seen"}, 64'd0, 64'd1);
    chk({tag, "_bus_req_cycles"}, 64'(nreq), 64'(exp_nreq));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_outs32", {breq32, bwe32, rv32, busy32, bbe32, rexc32}, 64'd0);
    chk("rst_data32", {baddr32, bwd32}, 64'd0);
    chk("rst_rdata32", 64'(rrd32), 64'd0);
    chk("rst_ready64", 64'(rdy64), 64'd1);
    chk("rst_outs64", {breq64, bwe64, rv64, busy64, bbe64, rexc64}, 64'd0);
    @(negedge clk);
    reset_n = 1;

    // Store byte at offset 3, ack in the first bus cycle
    run("sb", 0, 1, 2'd0, 0, 32'h1003, 64'h123456A5, 1, 64'h0,
        64'h0, 2'b00, 2, 1, 8'h08, 64'hA5000000);
    // Load half at offset 2 after three wait cycles, signed and unsigned
    run("lh", 0, 0, 2'd1, 0, 32'h2, 64'h0, 4, 64'h80011234,
        64'hFFFF8001, 2'b00, 5, 4, 8'h0, 64'h0);
    run("lhu", 0, 0, 2'd1, 1, 32'h2, 64'h0, 4, 64'h80011234,
        64'h00008001, 2'b00, 5, 4, 8'h0, 64'h0);
    // Load byte signed, negative
    run("lb", 0, 0, 2'd0, 0, 32'h41, 64'h0, 1, 64'h00008000,
        64'hFFFFFF80, 2'b00, 2, 1, 8'h0, 64'h0);
    // Misaligned half, and dword size on a 32-bit bus
    run("mis", 0, 0, 2'd1, 0, 32'h1, 64'h0, 0, 64'h0,
        64'h0, 2'b01, 1, 0, 8'h0, 64'h0);
    run("sz3", 0, 1, 2'd3, 0, 32'h0, 64'h55, 0, 64'h0,
        64'h0, 2'b01, 1, 0, 8'h0, 64'h0);
    // Word store with no ack times out after TIMEOUT bus cycles
    run("tmo", 0, 1, 2'd2, 0, 32'h10, 64'hDEADBEEF, 0, 64'h0,
        64'h0, 2'b10, 5, 4, 8'h0F, 64'hDEADBEEF);
    // Late ack in cycle 6 must be ignored
    back32 = 1; brd32 = 32'h12345678;
    @(negedge clk);
    chk("late_ack_rv", 64'(rv32), 64'd0);
    chk("late_ack_ready", 64'(rdy32), 64'd1);
    back32 = 0;
    @(negedge clk);
    chk("late_ack_rv2", 64'(rv32), 64'd0);
    run("lw_after", 0, 0, 2'd2, 0, 32'h4, 64'h0, 2, 64'hCAFEF00D,
        64'hCAFEF00D, 2'b00, 3, 2, 8'h0, 64'h0);

    // 64-bit bus: dword load, unsigned byte at top lane, half store
    run("ld64", 1, 0, 2'd3, 0, 32'h8, 64'h0, 1, 64'h8000000000000001,
        64'h8000000000000001, 2'b00, 2, 1, 8'h0, 64'h0);
    run("lbu64", 1, 0, 2'd0, 1, 32'hF, 64'h0, 2, 64'h80123456789ABCDE,
        64'h80, 2'b00, 3, 2, 8'h0, 64'h0);
    run("sh64", 1, 1, 2'd1, 0, 32'h6, 64'hFFFFBEEF, 1, 64'h0,
        64'h0, 2'b00, 2, 1, 8'hC0, 64'hBEEF000000000000);
    run("mis64", 1, 0, 2'd2, 0, 32'hC + 32'h2, 64'h0, 0, 64'h0,
        64'h0, 2'b01, 1, 0, 8'h0, 64'h0);

    // Back-to-back: req_valid held, second request only accepted after RESP
    @(negedge clk);
    v32 = 1; we32 = 1; sz32 = 2'd2; un32 = 0; addr32 = 32'h100; wd32 = 32'h11111111;
    sb.push_back('{64'h0, 2'b00});
    @(posedge clk);
    #1;
    we32 = 0; sz32 = 2'd0; un32 = 1; addr32 = 32'h203;
    sb.push_back('{64'h9A, 2'b00});
    @(negedge clk);
    chk("b2b_c1_ready", 64'(rdy32), 64'd0);
    chk("b2b_c1_addr", 64'(baddr32), 64'h100);
    back32 = 1;
    @(negedge clk);
    back32 = 0;
    chk("b2b_c2_ready", 64'(rdy32), 64'd0);
    chk("b2b_c2_rv", 64'(rv32), 64'd1);
    sb_check("b2b_a", {32'h0, rrd32}, rexc32);
    @(negedge clk);
    chk("b2b_c3_ready", 64'(rdy32), 64'd1);
    chk("b2b_c3_breq", 64'(breq32), 64'd0);
    @(posedge clk);
    #1;
    v32 = 0;
    @(negedge clk);
    chk("b2b_c4_breq", 64'(breq32), 64'd1);
    chk("b2b_c4_addr", 64'(baddr32), 64'h200);
    back32 = 1; brd32 = 32'h9A000000;
    @(negedge clk);
    back32 = 0;
    chk("b2b_c5_rv", 64'(rv32), 64'd1);
    sb_check("b2b_b", {32'h0, rrd32}, rexc32);

    // Reset in the middle of a bus transaction: no response produced
    @(negedge clk);
    v32 = 1; we32 = 0; sz32 = 2'd2; addr32 = 32'h20;
    @(posedge clk);
    #1;
    v32 = 0;
    @(negedge clk);
    chk("abort_breq_before", 64'(breq32), 64'd1);
    #2;
    reset_n = 0;
    #1;
    chk("abort_breq_async", 64'(breq32), 64'd0);
    chk("abort_ready", 64'(rdy32), 64'd1);
    chk("abort_busy", 64'(busy32), 64'd0);
    @(negedge clk);
    chk("abort_rv1", 64'(rv32), 64'd0);
    reset_n = 1;
    @(negedge clk);
    chk("abort_rv2", 64'(rv32), 64'd0);
    chk("abort_ready_after", 64'(rdy32), 64'd1);
    @(negedge clk);
    chk("abort_rv3", 64'(rv32), 64'd0);
    run("post_rst", 0, 0, 2'd1, 1, 32'h32, 64'h0, 1, 64'hABCD0000,
        64'h0000ABCD, 2'b00, 2, 1, 8'h0, 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
